// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues req/ack reads to instruction memory, feeds IF/ID.
// Optional FETCH_PERF_EN adds perf_fetched/perf_dropped counter ports.
module fetch_stage #(
  parameter int unsigned          XLEN      = 32,
  parameter logic [XLEN-1:0]      RESET_PC  = '0,
  parameter logic [31:0]          NOP_INSTR = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            PCSrc,
  input  logic [XLEN-1:0] branch_target,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  output logic            if_valid,
  output logic [XLEN-1:0] if_pc,
  output logic [31:0]     if_instr
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]     perf_fetched,
  output logic [31:0]     perf_dropped
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD} state_e;

  state_e          state_q, state_d;
  logic            req_q, req_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic            drop_q, drop_d;
  logic [XLEN-1:0] redir_q, redir_d;
  logic            valid_q, valid_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [31:0]     instr_q, instr_d;
  logic [XLEN-1:0] hold_pc_q, hold_pc_d;
  logic [31:0]     hold_instr_q, hold_instr_d;
  logic            placed;

  always_comb begin
    state_d      = state_q;
    req_d        = req_q;
    addr_d       = addr_q;
    drop_d       = drop_q;
    redir_d      = redir_q;
    valid_d      = valid_q;
    pc_d         = pc_q;
    instr_d      = instr_q;
    hold_pc_d    = hold_pc_q;
    hold_instr_d = hold_instr_q;
    placed       = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        state_d = S_WAIT;
        req_d   = 1'b1;
        addr_d  = PCSrc ? branch_target : RESET_PC;
      end
      S_WAIT: begin
        if (imem_ack) begin
          if (drop_q || PCSrc) begin
            // Stale response: retire it and re-aim at the newest redirect target.
            drop_d = 1'b0;
            addr_d = PCSrc ? branch_target : redir_q;
          end else if (stall) begin
            hold_pc_d    = addr_q;
            hold_instr_d = imem_rdata;
            req_d        = 1'b0;
            state_d      = S_HOLD;
          end else begin
            placed  = 1'b1;
            pc_d    = addr_q;
            instr_d = imem_rdata;
            addr_d  = addr_q + XLEN'(4);
          end
        end else if (PCSrc) begin
          drop_d  = 1'b1;
          redir_d = branch_target;
        end
      end
      S_HOLD: begin
        if (PCSrc) begin
          req_d   = 1'b1;
          addr_d  = branch_target;
          state_d = S_WAIT;
        end else if (!stall) begin
          placed  = 1'b1;
          pc_d    = hold_pc_q;
          instr_d = hold_instr_q;
          req_d   = 1'b1;
          addr_d  = hold_pc_q + XLEN'(4);
          state_d = S_WAIT;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Flush beats stall; otherwise an unstalled cycle without a new instruction is a bubble.
    if (PCSrc) begin
      valid_d = 1'b0;
      instr_d = NOP_INSTR;
    end else if (placed) begin
      valid_d = 1'b1;
    end else if (!stall) begin
      valid_d = 1'b0;
      instr_d = NOP_INSTR;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      req_q        <= 1'b0;
      addr_q       <= RESET_PC;
      drop_q       <= 1'b0;
      redir_q      <= '0;
      valid_q      <= 1'b0;
      pc_q         <= '0;
      instr_q      <= NOP_INSTR;
      hold_pc_q    <= '0;
      hold_instr_q <= '0;
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      addr_q       <= addr_d;
      drop_q       <= drop_d;
      redir_q      <= redir_d;
      valid_q      <= valid_d;
      pc_q         <= pc_d;
      instr_q      <= instr_d;
      hold_pc_q    <= hold_pc_d;
      hold_instr_q <= hold_instr_d;
    end
  end

  assign imem_req  = req_q;
  assign imem_addr = addr_q;
  assign if_valid  = valid_q;
  assign if_pc     = pc_q;
  assign if_instr  = instr_q;

`ifdef FETCH_PERF_EN
  logic        discarded;
  logic [31:0] perf_fetched_q, perf_fetched_d;
  logic [31:0] perf_dropped_q, perf_dropped_d;

  always_comb begin
    discarded      = ((state_q == S_WAIT) && imem_ack && (drop_q || PCSrc)) ||
                     ((state_q == S_HOLD) && PCSrc);
    perf_fetched_d = perf_fetched_q + 32'(placed);
    perf_dropped_d = perf_dropped_q + 32'(discarded);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fetched_q <= '0;
      perf_dropped_q <= '0;
    end else begin
      perf_fetched_q <= perf_fetched_d;
      perf_dropped_q <= perf_dropped_d;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_dropped = perf_dropped_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus an in-order scoreboard of
// accepted responses, compared whenever a fresh instruction appears on if_*.
module tb_fetch_stage;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        PCSrc = 1'b0;
  logic [31:0] branch_target = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_dropped;
`endif

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t        sb[$];
  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  fetch_stage #(.XLEN(32), .RESET_PC(32'h0), .NOP_INSTR(NOP)) dut (
    .clk(clk), .reset(reset), .stall(stall), .PCSrc(PCSrc), .branch_target(branch_target),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr)
`ifdef FETCH_PERF_EN
    , .perf_fetched(perf_fetched), .perf_dropped(perf_dropped)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hBEEF, a[15:0]};
  endfunction

  // One clock: ack only a live request; push the response if it will reach if_*,
  // then pop/compare when a fresh (not stall-held) instruction is visible.
  task automatic clock_dut(input bit ack, input bit stl, input bit pcs,
                           input logic [31:0] tgt, input bit accept);
    exp_t e;
    imem_ack      = ack && imem_req;
    imem_rdata    = mem_word(imem_addr);
    stall         = stl;
    PCSrc         = pcs;
    branch_target = tgt;
    if (imem_ack && accept) begin
      e.pc    = imem_addr;
      e.instr = mem_word(imem_addr);
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    imem_ack = 1'b0;
    stall    = 1'b0;
    PCSrc    = 1'b0;
    if (if_valid && !(stl && !pcs) && !reset) begin
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL sb_unexpected: got pc %h instr %h, required no instruction", if_pc, if_instr);
      end else begin
        e = sb.pop_front();
        if (if_pc !== e.pc || if_instr !== e.instr) begin
          miscompares++;
          $display("FAIL sb_order: got pc %h instr %h, required pc %h instr %h",
                   if_pc, if_instr, e.pc, e.instr);
        end
      end
    end
  endtask

  task automatic do_reset();
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL sb_leftover: got %0d pending, required 0", sb.size());
    end
    sb.delete();
    reset = 1'b1;
    clock_dut(0, 0, 0, '0, 0);
    clock_dut(0, 0, 0, '0, 0);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    vectors++; if (imem_req !== 1'b0) begin miscompares++; $display("FAIL rst_req: got %b required 0", imem_req); end
    vectors++; if (imem_addr !== 32'h0) begin miscompares++; $display("FAIL rst_addr: got %h required 0", imem_addr); end
    vectors++; if (if_valid !== 1'b0) begin miscompares++; $display("FAIL rst_valid: got %b required 0", if_valid); end
    vectors++; if (if_pc !== 32'h0) begin miscompares++; $display("FAIL rst_pc: got %h required 0", if_pc); end
    vectors++; if (if_instr !== NOP) begin miscompares++; $display("FAIL rst_instr: got %h required %h", if_instr, NOP); end
    clock_dut(0, 0, 0, '0, 0);
    vectors++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0 || if_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_issue: got req %b addr %h valid %b, required 1 0 0", imem_req, imem_addr, if_valid);
    end
  endtask

  task automatic test_sequential();
    do_reset();
    clock_dut(0, 0, 0, '0, 0);
    for (int unsigned i = 0; i < 4; i++) begin
      vectors++;
      if (imem_addr !== 32'(4 * i) || imem_req !== 1'b1) begin
        miscompares++;
        $display("FAIL seq_addr: got req %b addr %h, required 1 %h", imem_req, imem_addr, 32'(4 * i));
      end
      clock_dut(1, 0, 0, '0, 1);
      vectors++;
      if (if_valid !== 1'b1 || if_pc !== 32'(4 * i)) begin
        miscompares++;
        $display("FAIL seq_pc: got valid %b pc %h, required 1 %h", if_valid, if_pc, 32'(4 * i));
      end
    end
  endtask

  task automatic test_ack_delay();
    do_reset();
    clock_dut(0, 0, 0, '0, 0);
    clock_dut(1, 0, 0, '0, 1);
    clock_dut(1, 0, 0, '0, 1);
    for (int unsigned i = 0; i < 3; i++) begin
      vectors++;
      if (imem_addr !== 32'h8 || imem_req !== 1'b1) begin
        miscompares++;
        $display("FAIL delay_hold: got req %b addr %h, required 1 00000008", imem_req, imem_addr);
      end
      clock_dut(0, 0, 0, '0, 0);
      vectors++;
      if (if_valid !== 1'b0 || if_instr !== NOP) begin
        miscompares++;
        $display("FAIL delay_bubble: got valid %b instr %h, required 0 %h", if_valid, if_instr, NOP);
      end
    end
    clock_dut(1, 0, 0, '0, 1);
    vectors++;
    if (if_valid !== 1'b1 || if_pc !== 32'h8) begin
      miscompares++;
      $display("FAIL delay_pc: got valid %b pc %h, required 1 00000008", if_valid, if_pc);
    end
  endtask

  task automatic test_redirect();
    do_reset();
    clock_dut(0, 0, 0, '0, 0);
    for (int unsigned i = 0; i < 4; i++) clock_dut(1, 0, 0, '0, 1);
    clock_dut(0, 0, 1, 32'h100, 0);
    vectors++;
    if (if_valid !== 1'b0 || imem_addr !== 32'h10 || imem_req !== 1'b1) begin
      miscompares++;
      $display("FAIL redir_flush: got valid %b addr %h req %b, required 0 00000010 1", if_valid, imem_addr, imem_req);
    end
    clock_dut(1, 0, 0, '0, 0);
    vectors++;
    if (imem_addr !== 32'h100 || if_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL redir_target: got addr %h valid %b, required 00000100 0", imem_addr, if_valid);
    end
    clock_dut(0, 0, 0, '0, 0);
    vectors++;
    if (if_valid !== 1'b0) begin miscompares++; $display("FAIL redir_wait: got valid %b required 0", if_valid); end
    clock_dut(1, 0, 0, '0, 1);
    vectors++;
    if (if_valid !== 1'b1 || if_pc !== 32'h100) begin
      miscompares++;
      $display("FAIL redir_pc: got valid %b pc %h, required 1 00000100", if_valid, if_pc);
    end
    clock_dut(0, 0, 1, 32'h200, 0);
    clock_dut(0, 0, 1, 32'h300, 0);
    clock_dut(1, 0, 0, '0, 0);
    vectors++;
    if (imem_addr !== 32'h300) begin miscompares++; $display("FAIL redir_latest: got %h required 00000300", imem_addr); end
    clock_dut(1, 0, 0, '0, 1);
  endtask

  task automatic test_back_to_back();
    do_reset();
    clock_dut(0, 0, 0, '0, 0);
    clock_dut(1, 0, 0, '0, 1);
    clock_dut(1, 0, 1, 32'h40, 0);
    vectors++;
    if (imem_addr !== 32'h40 || if_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL ackpc_same: got addr %h valid %b, required 00000040 0", imem_addr, if_valid);
    end
    clock_dut(1, 0, 0, '0, 1);
    clock_dut(1, 0, 0, '0, 1);
    vectors++;
    if (if_pc !== 32'h44 || imem_addr !== 32'h48) begin
      miscompares++;
      $display("FAIL b2b_pc: got pc %h addr %h, required 00000044 00000048", if_pc, imem_addr);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    clock_dut(0, 0, 1, 32'hFFFF_FFF8, 0);
    vectors++;
    if (imem_addr !== 32'hFFFF_FFF8 || imem_req !== 1'b1) begin
      miscompares++;
      $display("FAIL wrap_idle: got addr %h req %b, required fffffff8 1", imem_addr, imem_req);
    end
    clock_dut(1, 0, 0, '0, 1);
    clock_dut(1, 0, 0, '0, 1);
    vectors++;
    if (imem_addr !== 32'h0 || if_pc !== 32'hFFFF_FFFC) begin
      miscompares++;
      $display("FAIL wrap_addr: got addr %h pc %h, required 00000000 fffffffc", imem_addr, if_pc);
    end
    clock_dut(1, 0, 0, '0, 1);
    vectors++;
    if (imem_addr !== 32'h4) begin miscompares++; $display("FAIL wrap_next: got %h required 00000004", imem_addr); end
  endtask

  task automatic test_stall_hold();
    do_reset();
    clock_dut(0, 0, 0, '0, 0);
    for (int unsigned i = 0; i < 3; i++) clock_dut(1, 0, 0, '0, 1);
    clock_dut(1, 1, 0, '0, 1);
    vectors++;
    if (imem_req !== 1'b0 || if_valid !== 1'b1 || if_pc !== 32'h8) begin
      miscompares++;
      $display("FAIL hold_enter: got req %b valid %b pc %h, required 0 1 00000008", imem_req, if_valid, if_pc);
    end
    clock_dut(1, 1, 0, '0, 0);
    vectors++;
    if (imem_req !== 1'b0 || if_pc !== 32'h8) begin
      miscompares++;
      $display("FAIL hold_frozen: got req %b pc %h, required 0 00000008", imem_req, if_pc);
    end
    clock_dut(0, 0, 0, '0, 0);
    vectors++;
    if (if_valid !== 1'b1 || if_pc !== 32'hC || imem_req !== 1'b1 || imem_addr !== 32'h10) begin
      miscompares++;
      $display("FAIL hold_release: got valid %b pc %h req %b addr %h, required 1 0000000c 1 00000010",
               if_valid, if_pc, imem_req, imem_addr);
    end
  endtask

  task automatic test_flush_in_hold();
    do_reset();
    clock_dut(0, 0, 0, '0, 0);
    clock_dut(1, 0, 0, '0, 1);
    clock_dut(1, 0, 0, '0, 1);
    clock_dut(1, 1, 0, '0, 1);
    void'(sb.pop_back());
    clock_dut(0, 1, 1, 32'h80, 0);
    vectors++;
    if (if_valid !== 1'b0 || if_instr !== NOP || imem_req !== 1'b1 || imem_addr !== 32'h80) begin
      miscompares++;
      $display("FAIL hold_flush: got valid %b instr %h req %b addr %h, required 0 %h 1 00000080",
               if_valid, if_instr, imem_req, imem_addr, NOP);
    end
    clock_dut(1, 0, 0, '0, 1);
    vectors++;
    if (if_pc !== 32'h80) begin miscompares++; $display("FAIL hold_flush_pc: got %h required 00000080", if_pc); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    clock_dut(0, 0, 0, '0, 0);
    clock_dut(1, 0, 0, '0, 1);
    reset = 1'b1;
    clock_dut(0, 0, 0, '0, 0);
    reset = 1'b0;
    vectors++;
    if (imem_req !== 1'b0 || if_valid !== 1'b0 || imem_addr !== 32'h0) begin
      miscompares++;
      $display("FAIL rstmid_state: got req %b valid %b addr %h, required 0 0 0", imem_req, if_valid, imem_addr);
    end
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    imem_ack = 1'b0;
    vectors++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0 || if_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL rstmid_late_ack: got req %b addr %h valid %b, required 1 0 0", imem_req, imem_addr, if_valid);
    end
  endtask

`ifdef FETCH_PERF_EN
  task automatic test_perf();
    do_reset();
    vectors++;
    if (perf_fetched !== 32'd0 || perf_dropped !== 32'd0) begin
      miscompares++;
      $display("FAIL perf_rst: got %0d %0d, required 0 0", perf_fetched, perf_dropped);
    end
    clock_dut(0, 0, 0, '0, 0);
    for (int unsigned i = 0; i < 4; i++) clock_dut(1, 0, 0, '0, 1);
    clock_dut(1, 0, 1, 32'h40, 0);
    clock_dut(1, 0, 0, '0, 1);
    clock_dut(0, 0, 1, 32'h80, 0);
    clock_dut(1, 0, 0, '0, 0);
    vectors++;
    if (perf_fetched !== 32'd5 || perf_dropped !== 32'd2) begin
      miscompares++;
      $display("FAIL perf_count: got %0d %0d, required 5 2", perf_fetched, perf_dropped);
    end
    reset = 1'b1;
    clock_dut(0, 0, 0, '0, 0);
    reset = 1'b0;
    vectors++;
    if (perf_fetched !== 32'd0 || perf_dropped !== 32'd0 || imem_req !== 1'b0) begin
      miscompares++;
      $display("FAIL perf_rstmid: got %0d %0d req %b, required 0 0 0", perf_fetched, perf_dropped, imem_req);
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    #1;
    test_reset();
    test_sequential();
    test_ack_delay();
    test_redirect();
    test_back_to_back();
    test_wrap();
    test_stall_hold();
    test_flush_in_hold();
    test_reset_mid();
`ifdef FETCH_PERF_EN
    test_perf();
`endif
    do_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
